// File: rtl/swan128_ctr_ctrl.sv
// swan128_ctr_ctrl: CTR-mode front end for the serial SWAN128-K128 core.
// Each accepted block gets its own counter block {nonce, ctr}. The core is
// started on that block, and its keystream is XORed with the data on the way out.
// A watchdog flags a core that never answers.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_load_i         load key/nonce/ctr (honoured in IDLE only)
//   cfg_key_i          cipher key
//   cfg_nonce_i        nonce, upper part of the counter block
//   cfg_ctr_i          initial counter, lower part of the counter block
//   in_valid_i/in_ready_o/in_data_i     input block stream
//   out_valid_o/out_ready_i/out_data_o  result stream (data ^ keystream)
//   err_o              sticky watchdog error
//   core_start_o       start pulse to the core
//   core_inp_o         counter block, driven only while starting
//   core_key_o         latched key
//   core_ready_i       core done
//   core_out_i         keystream block
//
// Optional build macro SWAN_CTR_PREFETCH_EN: keystream is generated ahead of
// data into ks_buf, so an accepted block returns after a single cycle.
module swan128_ctr_ctrl #(
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned KEY_SIZE   = 128,
  parameter int unsigned CTR_SIZE   = 64,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_load_i,
  input  logic [KEY_SIZE-1:0]            cfg_key_i,
  input  logic [BLOCK_SIZE-CTR_SIZE-1:0] cfg_nonce_i,
  input  logic [CTR_SIZE-1:0]            cfg_ctr_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [BLOCK_SIZE-1:0]          in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [BLOCK_SIZE-1:0]          out_data_o,
  output logic                           err_o,
  output logic                           core_start_o,
  output logic [BLOCK_SIZE-1:0]          core_inp_o,
  output logic [KEY_SIZE-1:0]            core_key_o,
  input  logic                           core_ready_i,
  input  logic [BLOCK_SIZE-1:0]          core_out_i
);

  localparam int unsigned NONCE_SIZE = BLOCK_SIZE - CTR_SIZE;
  localparam int unsigned WDOG_W     = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_GUARD,
    ST_WAIT,
    ST_OUT,
    ST_ERR
  } state_t;

  state_t                  state_q;
  logic                    cfg_ok_q;
  logic                    err_q;
  logic [KEY_SIZE-1:0]     key_q;
  logic [NONCE_SIZE-1:0]   nonce_q;
  logic [CTR_SIZE-1:0]     ctr_q;
  logic [WDOG_W-1:0]       wdog_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [BLOCK_SIZE-1:0]   out_data_q;
  logic                    core_start_q;
  logic [BLOCK_SIZE-1:0]   core_inp_q;
`ifdef SWAN_CTR_PREFETCH_EN
  logic [BLOCK_SIZE-1:0]   ks_buf_q;
  logic                    ks_valid_q;
  logic                    out_hold_c;

  // Result still pending after this edge; blocks a new accept.
  assign out_hold_c = out_valid_q & ~out_ready_i;
`else
  logic [BLOCK_SIZE-1:0]   data_q;
`endif

  // Controller FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_ok_q     <= 1'b0;
      err_q        <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      wdog_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      core_start_q <= 1'b0;
      core_inp_q   <= '0;
`ifdef SWAN_CTR_PREFETCH_EN
      ks_buf_q     <= '0;
      ks_valid_q   <= 1'b0;
`else
      data_q       <= '0;
`endif
    end else begin
`ifdef SWAN_CTR_PREFETCH_EN
      // Output handshake runs independently of keystream generation.
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (cfg_load_i) begin
            // Configuration takes priority over a simultaneous input block.
            key_q    <= cfg_key_i;
            nonce_q  <= cfg_nonce_i;
            ctr_q    <= cfg_ctr_i;
            cfg_ok_q <= 1'b1;
`ifdef SWAN_CTR_PREFETCH_EN
            ks_valid_q <= 1'b0;
            in_ready_q <= 1'b0;
`else
            in_ready_q <= 1'b1;
`endif
          end else if (in_valid_i && in_ready_q) begin
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b1;
            core_inp_q   <= {nonce_q, ctr_q};
            state_q      <= ST_START;
`ifdef SWAN_CTR_PREFETCH_EN
            // Consume the buffered keystream and immediately prefetch the next.
            out_data_q  <= in_data_i ^ ks_buf_q;
            out_valid_q <= 1'b1;
            ks_valid_q  <= 1'b0;
`else
            data_q <= in_data_i;
`endif
`ifdef SWAN_CTR_PREFETCH_EN
          end else if (cfg_ok_q && !ks_valid_q) begin
            // Self-issued keystream request, no data needed.
            core_start_q <= 1'b1;
            core_inp_q   <= {nonce_q, ctr_q};
            state_q      <= ST_START;
          end else begin
            in_ready_q <= ks_valid_q & ~out_hold_c;
          end
`else
          end else begin
            in_ready_q <= cfg_ok_q;
          end
`endif
        end

        ST_START: begin
          core_start_q <= 1'b0;
          core_inp_q   <= '0;
          ctr_q        <= ctr_q + CTR_SIZE'(1);
          state_q      <= ST_GUARD;
        end

        // core_ready may still be high from the previous operation here.
        ST_GUARD: begin
          wdog_q  <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (core_ready_i) begin
`ifdef SWAN_CTR_PREFETCH_EN
            ks_buf_q   <= core_out_i;
            ks_valid_q <= 1'b1;
            in_ready_q <= ~out_hold_c;
            state_q    <= ST_IDLE;
`else
            out_data_q  <= data_q ^ core_out_i;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
`endif
          end else if (wdog_q == WDOG_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end

        ST_OUT: begin
`ifdef SWAN_CTR_PREFETCH_EN
          state_q <= ST_IDLE;
`else
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= cfg_ok_q;
            state_q     <= ST_IDLE;
          end
`endif
        end

        // Terminal until reset.
        ST_ERR: begin
          state_q <= ST_ERR;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign err_o        = err_q;
  assign core_start_o = core_start_q;
  assign core_inp_o   = core_inp_q;
  assign core_key_o   = key_q;

endmodule

// File: tb/tb_swan128_ctr_ctrl.sv
// Testbench for swan128_ctr_ctrl with a stub serial core (96-cycle latency,
// ready held until the next start) and directed vectors.
module tb_swan128_ctr_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [63:0]  cfg_nonce = '0;
  logic [63:0]  cfg_ctr = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         err;
  logic         core_start;
  logic [127:0] core_inp;
  logic [127:0] core_key;
  logic         core_ready = 1'b0;
  logic [127:0] core_out = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swan128_ctr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load_i  (cfg_load),
    .cfg_key_i   (cfg_key),
    .cfg_nonce_i (cfg_nonce),
    .cfg_ctr_i   (cfg_ctr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .err_o       (err),
    .core_start_o(core_start),
    .core_inp_o  (core_inp),
    .core_key_o  (core_key),
    .core_ready_i(core_ready),
    .core_out_i  (core_out)
  );

  // Stand-in cipher for the stub core.
  function automatic logic [127:0] ks_f(input logic [127:0] x, input logic [127:0] k);
    return {x[63:0], x[127:64]} ^ k ^ 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  endfunction

  // Stub core: ready rises 96 edges after start is sampled and stays high
  // (stale) through the cycle after the next start.
  int           core_cnt = 0;
  logic [127:0] core_lat = '0;
  logic         core_stuck = 1'b0;

  always @(posedge clk) begin
    if (core_start) begin
      core_cnt <= 96;
      core_lat <= core_inp;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_stuck) begin
        core_ready <= 1'b1;
        core_out   <= ks_f(core_lat, core_key);
      end else begin
        core_ready <= 1'b0;
      end
    end
  end

  // Drivers: entered and left on a falling edge.
  task automatic do_cfg(input logic [127:0] k, input logic [63:0] n, input logic [63:0] c);
    cfg_key   = k;
    cfg_nonce = n;
    cfg_ctr   = c;
    cfg_load  = 1'b1;
    @(negedge clk);
    cfg_load  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, output bit ok);
    int w = 0;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    ok       = in_ready;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 400) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [387:0] v;
    repeat (3) @(negedge clk);
    v = {in_ready, out_valid, err, core_start, out_data, core_inp, core_key};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_during: outputs %h want 0", v);
    end
    rst = 1'b0;
    @(negedge clk);
    v = {in_ready, out_valid, err, core_start, out_data, core_inp, core_key};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_after: outputs %h want 0", v);
    end
  endtask

`ifdef SWAN_CTR_PREFETCH_EN
  task automatic test_prefetch();
    logic [127:0] k = 128'h00112233445566778899AABBCCDDEEFF;
    logic [63:0]  n = 64'hCAFEBABEDEADBEEF;
    logic [63:0]  c0 = 64'h0000000000000010;
    logic [63:0]  c1 = 64'h0000000000000011;
    logic [127:0] d1 = 128'h13579BDF02468ACE_FEDCBA9876543210;
    logic [127:0] d2 = 128'hA5A5A5A55A5A5A5A_0F0F0F0FF0F0F0F0;
    logic [127:0] exp;
    bit ok;
    int c;
    do_cfg(k, n, c0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pf_ready_after_cfg: got %b want 0", in_ready);
    end
    repeat (99) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pf_ready_prefetched: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d1;
    @(negedge clk);
    in_valid = 1'b0;
    exp = d1 ^ ks_f({n, c0}, k);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL pf_one_cycle: valid %b data %h want 1 %h", out_valid, out_data, exp);
    end
    take_out();
    c = 1;
    while (!in_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 98) begin
      errors++;
      $display("FAIL pf_refill: in_ready after %0d cycles want 98", c);
    end
    send_block(d2, ok);
    exp = d2 ^ ks_f({n, c1}, k);
    checks++;
    if (!ok || out_valid !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL pf_second: ok %b valid %b data %h want %h", ok, out_valid, out_data, exp);
    end
    take_out();
  endtask
`else
  task automatic test_cfg_collision();
    do_cfg(128'h1, 64'h2, 64'h3);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready: got %b want 1", in_ready);
    end
    cfg_key   = '0;
    cfg_nonce = '0;
    cfg_ctr   = '0;
    cfg_load  = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    @(negedge clk);
    cfg_load  = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (core_start !== 1'b0 || in_ready !== 1'b1 || core_key !== '0) begin
      errors++;
      $display("FAIL cfg_wins: start %b ready %b key %h want 0 1 0", core_start, in_ready, core_key);
    end
  endtask

  task automatic test_zero_block();
    logic [127:0] exp;
    bit ok;
    int c;
    send_block('0, ok);
    checks++;
    if (!ok || core_start !== 1'b1 || core_inp !== '0) begin
      errors++;
      $display("FAIL zero_start: ok %b start %b inp %h want 1 1 0", ok, core_start, core_inp);
    end
    wait_out(c);
    checks++;
    if (c != 98) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 98", c);
    end
    exp = ks_f('0, '0);
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL zero_data: got %h want %h", out_data, exp);
    end
    take_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_release: valid %b ready %b want 0 1", out_valid, in_ready);
    end
    send_block('0, ok);
    checks++;
    if (!ok || core_inp !== {64'h0, 64'h1}) begin
      errors++;
      $display("FAIL zero_ctr1: ok %b inp %h want 1 %h", ok, core_inp, {64'h0, 64'h1});
    end
    wait_out(c);
    exp = ks_f({64'h0, 64'h1}, '0);
    checks++;
    if (c != 98 || out_data !== exp) begin
      errors++;
      $display("FAIL zero_second: lat %0d data %h want 98 %h", c, out_data, exp);
    end
    take_out();
  endtask

  task automatic test_ctr_wrap();
    logic [127:0] k = 128'h00112233445566778899AABBCCDDEEFF;
    logic [63:0]  n = 64'hCAFEBABEDEADBEEF;
    logic [63:0]  ones = 64'hFFFFFFFFFFFFFFFF;
    logic [127:0] d1 = 128'h0123456789ABCDEF_1122334455667788;
    logic [127:0] d2 = 128'hFFEEDDCCBBAA9988_7766554433221100;
    logic [127:0] exp;
    bit ok;
    int c;
    do_cfg(k, n, ones);
    send_block(d1, ok);
    checks++;
    if (!ok || core_inp !== {n, ones}) begin
      errors++;
      $display("FAIL wrap_inp1: ok %b inp %h want %h", ok, core_inp, {n, ones});
    end
    repeat (10) @(negedge clk);
    // Load attempt while busy must be ignored.
    cfg_key  = ~k;
    cfg_ctr  = 64'h5;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    checks++;
    if (core_key !== k) begin
      errors++;
      $display("FAIL wrap_cfg_ignored: key %h want %h", core_key, k);
    end
    wait_out(c);
    exp = ks_f({n, ones}, k);
    checks++;
    if ((out_data ^ d1) !== exp) begin
      errors++;
      $display("FAIL wrap_ks1: got %h want %h", out_data ^ d1, exp);
    end
    take_out();
    send_block(d2, ok);
    checks++;
    if (!ok || core_inp !== {n, 64'h0}) begin
      errors++;
      $display("FAIL wrap_inp2: ok %b inp %h want %h", ok, core_inp, {n, 64'h0});
    end
    wait_out(c);
    exp = d2 ^ ks_f({n, 64'h0}, k);
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL wrap_data2: got %h want %h", out_data, exp);
    end
    take_out();
  endtask

  task automatic test_backpressure();
    logic [127:0] k = 128'h00112233445566778899AABBCCDDEEFF;
    logic [63:0]  n = 64'hCAFEBABEDEADBEEF;
    logic [127:0] d = 128'h5555AAAA5555AAAA_3333CCCC3333CCCC;
    logic [127:0] exp;
    bit ok;
    int c;
    send_block(d, ok);
    wait_out(c);
    exp = d ^ ks_f({n, 64'h1}, k);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || core_start !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid %b data %h ready %b start %b want 1 %h 0 0",
                 i, out_valid, out_data, in_ready, core_start, exp);
      end
      @(negedge clk);
    end
    take_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid %b ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int c = 0;
    core_stuck = 1'b1;
    send_block(128'h77, ok);
    while (!err && c < 400) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 257) begin
      errors++;
      $display("FAIL to_err_cycle: err after %0d cycles want 257", c);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0) begin
        errors++;
        $display("FAIL to_terminal[%0d]: err %b ready %b valid %b start %b want 1 0 0 0",
                 i, err, in_ready, out_valid, core_start);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL to_reset: err %b ready %b want 0 0", err, in_ready);
    end
    core_stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] kc = 128'hDEADBEEF00000000_0000000012345678;
    logic [63:0]  nc = 64'h0102030405060708;
    logic [63:0]  cc = 64'h00000000000000AA;
    logic [127:0] dc = 128'hC0FFEE00C0FFEE00_BADC0FFEBADC0FFE;
    logic [127:0] exp;
    bit ok;
    int c;
    do_cfg(128'h99, 64'h98, 64'h97);
    send_block(128'h42, ok);
    repeat (42) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_lost: valid %b ready %b want 0 0", out_valid, in_ready);
    end
    do_cfg(kc, nc, cc);
    send_block(dc, ok);
    checks++;
    if (!ok || core_inp !== {nc, cc}) begin
      errors++;
      $display("FAIL mid_inp: ok %b inp %h want %h", ok, core_inp, {nc, cc});
    end
    wait_out(c);
    checks++;
    if (c != 98) begin
      errors++;
      $display("FAIL mid_latency: got %0d want 98", c);
    end
    exp = dc ^ ks_f({nc, cc}, kc);
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL mid_data: got %h want %h", out_data, exp);
    end
    take_out();
  endtask
`endif

  initial begin
    test_reset();
`ifdef SWAN_CTR_PREFETCH_EN
    test_prefetch();
`else
    test_cfg_collision();
    test_zero_block();
    test_ctr_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swan128_ctr_ctrl.md
Name: swan128_ctr_ctrl

Overview:
- CTR-mode controller directly upstream of the serial SWAN128-K128 encryption core.
- Accepts plaintext or ciphertext blocks over a valid/ready stream.
- For each block, builds the counter block {nonce, ctr}, drives the core's start/inp/key, and waits for the core's ready.
- Returns data XOR keystream on an output valid/ready stream, and flags a core that never completes.

Parameters:
- BLOCK_SIZE, 128, block width in bits.
- KEY_SIZE, 128, key width in bits.
- CTR_SIZE, 64, counter width; nonce width is BLOCK_SIZE-CTR_SIZE.
- TIMEOUT, 255, maximum core cycles before err is raised; 8-bit watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cfg_load  in  1  load key/nonce/ctr. Honoured only in IDLE; ignored in any other state.
- cfg_key  in  [0:127]  cipher key.
- cfg_nonce  in  [0:63]  nonce, placed in the upper half of the counter block.
- cfg_ctr  in  [0:63]  initial counter.
- in_valid  in  1  input block valid.
- in_ready  out  1  input block accepted when in_valid & in_ready.
- in_data  in  [0:127]  plaintext or ciphertext.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  [0:127]  in_data XOR keystream.
- err  out  1  sticky watchdog error.
- core_start  out  1  start pulse to the core.
- core_inp  out  [0:127]  counter block {nonce, ctr}.
- core_key  out  [0:127]  latched key, held constant.
- core_ready  in  1  core done.
- core_out  in  [0:127]  keystream block.

Behaviour:
- Reset:
  - clk is the single clock. rst is asynchronous active-high and forces state to IDLE.
  - Reset clears cfg_ok, err, key, nonce and ctr.
  - All outputs are 0 during and after reset.
- Configuration:
  - cfg_load in IDLE latches key, nonce and ctr, and sets cfg_ok the next cycle.
  - cfg_load and in_valid in the same IDLE cycle: cfg_load wins, and no block is accepted that cycle.
- States: IDLE, START, GUARD, WAIT, OUT, ERR.
- IDLE:
  - in_ready = cfg_ok & !err.
  - On accept, capture in_data and go to START.
- START (1 cycle):
  - core_start=1; core_inp={nonce, ctr}.
  - ctr <= ctr+1, modulo 2^CTR_SIZE. 2^64-1 wraps to 0 with no flag.
  - Go to GUARD.
- GUARD (1 cycle):
  - core_ready is ignored, because it is stale from the previous operation.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - Watchdog increments every cycle.
  - If core_ready=1: out_data <= data ^ core_out, out_valid=1, go to OUT.
  - If the watchdog reaches TIMEOUT first: err=1, go to ERR.
- OUT:
  - out_valid and out_data are held stable until out_ready.
  - On transfer, go to IDLE.
  - out_ready is don't-care while out_valid=0.
- ERR:
  - Terminal state: in_ready=0, out_valid=0.
  - Exited only by rst.
- Latency and throughput:
  - With a 96-half-round core, out_valid rises exactly 98 cycles after the accept edge.
  - One block is in flight at a time.
- Outputs not in use:
  - core_inp is driven only in START and is 0 otherwise.
  - core_key is always the latched key.
- Reset mid-operation:
  - The block returns to IDLE and the in-flight block is lost.
  - The core itself is not reset. The GUARD state makes any stale core_ready harmless on the next start.

Optional Feature:
- Macro: SWAN_CTR_PREFETCH_EN.
- Defined:
  - In IDLE with cfg_ok & !ks_valid, the controller self-issues START/GUARD/WAIT without waiting for data.
  - core_out is stored in ks_buf, and ks_valid is set.
  - in_ready = ks_valid & !out_valid.
  - On accept: out_data = in_data ^ ks_buf, out_valid next cycle (1-cycle latency).
  - ks_valid clears on accept, and the next prefetch starts.
  - cfg_load clears ks_valid.
  - Watchdog and ERR are unchanged.
- Undefined: on-demand operation exactly as in Behaviour; ks_buf and ks_valid are absent.

Test Plan:
- Key, nonce and ctr 0; in_data=0 -> out_data equals the core's encryption of 128'h0 and appears 98 cycles after accept; on the second block core_inp = {64'h0, 64'h1}.
- cfg_ctr=64'hFFFFFFFFFFFFFFFF, send two blocks -> core_inp low halves are FFFF_FFFF_FFFF_FFFF then 0000_0000_0000_0000; in_data XOR out_data equals the core output each time.
- Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, no core_start; release -> one transfer, then in_ready=1.
- Stub core_ready stuck at 0 -> err=1 after TIMEOUT=255 WAIT cycles, in_ready stays 0; rst -> err=0, cfg_ok=0.
- Assert rst in WAIT cycle 40, then reconfigure and send a block -> correct result with full 98-cycle latency, no early completion from stale core_ready.
- SWAN_CTR_PREFETCH_EN: after cfg_load, wait 100 cycles, send a block -> out_valid 1 cycle after accept; next in_ready rises about 98 cycles later.
